// File: rtl/date_counter.sv
// Calendar date counter (year offset / month / day) advanced by day_tick and loadable via set_en.
// Leap years are computed on the absolute year BASE_YEAR + year.
module date_counter #(
  parameter int unsigned YEAR_MAX  = 974,
  parameter int unsigned BASE_YEAR = 2025
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       set_en,
  input  logic [9:0] set_year,
  input  logic [3:0] set_month,
  input  logic [4:0] set_day,
  output logic [9:0] year,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [4:0] max_day,
  output logic       month_carry,
  output logic       year_carry,
  output logic       wrap,
  output logic       set_err
);

  localparam logic [9:0] YMAX = YEAR_MAX[9:0];

  typedef enum logic [1:0] {IDLE, ADVANCE, LOAD} state_t;

  function automatic logic is_leap(input logic [9:0] yoff);
    int unsigned a;
    a = BASE_YEAR + 32'(yoff);
    return ((a % 32'd4) == 32'd0) &&
           (((a % 32'd100) != 32'd0) || ((a % 32'd400) == 32'd0));
  endfunction

  function automatic logic [4:0] days_in(input logic [9:0] y, input logic [3:0] m);
    logic [4:0] r;
    case (m)
      4'd2:                      r = is_leap(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   r = 5'd30;
      default:                   r = 5'd31;
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [9:0] year_q, year_d;
  logic [3:0] month_q, month_d;
  logic [4:0] day_q, day_d;
  logic       month_carry_q, month_carry_d;
  logic       year_carry_q, year_carry_d;
  logic       wrap_q, wrap_d;
  logic       set_err_q, set_err_d;
  logic       tick_pend_q, tick_pend_d;
  logic       set_pend_q, set_pend_d;
  logic [9:0] set_year_q, set_year_d;
  logic [3:0] set_month_q, set_month_d;
  logic [4:0] set_day_q, set_day_d;
  logic [4:0] cur_max;
  logic       set_ok;

  assign cur_max = days_in(year_q, month_q);
  assign set_ok  = (set_year_q <= YMAX) &&
                   (set_month_q >= 4'd1) && (set_month_q <= 4'd12) &&
                   (set_day_q != 5'd0) &&
                   (set_day_q <= days_in(set_year_q, set_month_q));

  always_comb begin
    state_d       = state_q;
    year_d        = year_q;
    month_d       = month_q;
    day_d         = day_q;
    month_carry_d = 1'b0;
    year_carry_d  = 1'b0;
    wrap_d        = 1'b0;
    set_err_d     = 1'b0;
    tick_pend_d   = tick_pend_q;
    set_pend_d    = set_pend_q;
    set_year_d    = set_year_q;
    set_month_d   = set_month_q;
    set_day_d     = set_day_q;

    case (state_q)
      IDLE: begin
        if (set_en || set_pend_q) begin
          state_d    = LOAD;
          set_pend_d = 1'b0;
          // A fresh set_en shares the cycle with any day_tick and wins; a tick
          // arriving while a pending load is serviced is kept for later.
          if (!set_pend_q) begin
            set_year_d  = set_year;
            set_month_d = set_month;
            set_day_d   = set_day;
          end else if (day_tick) begin
            tick_pend_d = 1'b1;
          end
        end else if (day_tick || tick_pend_q) begin
          state_d     = ADVANCE;
          tick_pend_d = 1'b0;
        end
      end

      ADVANCE, LOAD: begin
        state_d = IDLE;
        if (state_q == ADVANCE) begin
          if (day_q < cur_max) begin
            day_d = day_q + 5'd1;
          end else begin
            day_d         = 5'd1;
            month_carry_d = 1'b1;
            if (month_q < 4'd12) begin
              month_d = month_q + 4'd1;
            end else begin
              month_d      = 4'd1;
              year_carry_d = 1'b1;
              if (year_q < YMAX) begin
                year_d = year_q + 10'd1;
              end else begin
                year_d = '0;
                wrap_d = 1'b1;
              end
            end
          end
        end else begin
          if (set_ok) begin
            year_d  = set_year_q;
            month_d = set_month_q;
            day_d   = set_day_q;
          end else begin
            set_err_d = 1'b1;
          end
        end
        if (day_tick) tick_pend_d = 1'b1;
        if (set_en && !set_pend_q) begin
          set_pend_d  = 1'b1;
          set_year_d  = set_year;
          set_month_d = set_month;
          set_day_d   = set_day;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      year_q        <= '0;
      month_q       <= 4'd1;
      day_q         <= 5'd1;
      month_carry_q <= 1'b0;
      year_carry_q  <= 1'b0;
      wrap_q        <= 1'b0;
      set_err_q     <= 1'b0;
      tick_pend_q   <= 1'b0;
      set_pend_q    <= 1'b0;
      set_year_q    <= '0;
      set_month_q   <= '0;
      set_day_q     <= '0;
    end else begin
      state_q       <= state_d;
      year_q        <= year_d;
      month_q       <= month_d;
      day_q         <= day_d;
      month_carry_q <= month_carry_d;
      year_carry_q  <= year_carry_d;
      wrap_q        <= wrap_d;
      set_err_q     <= set_err_d;
      tick_pend_q   <= tick_pend_d;
      set_pend_q    <= set_pend_d;
      set_year_q    <= set_year_d;
      set_month_q   <= set_month_d;
      set_day_q     <= set_day_d;
    end
  end

  assign year        = year_q;
  assign month       = month_q;
  assign day         = day_q;
  assign max_day     = cur_max;
  assign month_carry = month_carry_q;
  assign year_carry  = year_carry_q;
  assign wrap        = wrap_q;
  assign set_err     = set_err_q;

endmodule

// File: tb/tb_date_counter.sv
// Scoreboard bench for date_counter: stimulus queues expected outcomes with due cycles,
// a negedge monitor pops one entry for every visible date change or pulse.
module tb_date_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       day_tick = 1'b0;
  logic       set_en = 1'b0;
  logic [9:0] set_year = '0;
  logic [3:0] set_month = '0;
  logic [4:0] set_day = '0;
  logic [9:0] year;
  logic [3:0] month;
  logic [4:0] day;
  logic [4:0] max_day;
  logic       month_carry, year_carry, wrap, set_err;

  date_counter #(.YEAR_MAX(974), .BASE_YEAR(2025)) dut (
    .clk(clk), .rst(rst), .day_tick(day_tick), .set_en(set_en),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .year(year), .month(month), .day(day), .max_day(max_day),
    .month_carry(month_carry), .year_carry(year_carry), .wrap(wrap), .set_err(set_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string nm;
    int y, m, d, md;
    bit mc, yc, wr, er;
    int due;
  } exp_t;
  exp_t q[$];

  int cy = 0, cm = 1, cd = 1;

  function automatic int mdays(int y, int m);
    int a;
    bit leap;
    a = 2025 + y;
    leap = (a % 400 == 0) || ((a % 4 == 0) && (a % 100 != 0));
    if (m == 2) return leap ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic push(string nm, int y, int m, int d, bit mc, bit yc, bit wr, bit er, int due);
    exp_t e;
    e.nm = nm; e.y = y; e.m = m; e.d = d; e.md = mdays(y, m);
    e.mc = mc; e.yc = yc; e.wr = wr; e.er = er; e.due = due;
    q.push_back(e);
  endtask

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor: any date change or pulse is one DUT response.
  logic [18:0] prev;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev = {year, month, day};
    end else if ({year, month, day} != prev || month_carry || year_carry || wrap || set_err) begin
      prev = {year, month, day};
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got %0d-%0d-%0d c=%b%b%b e=%b at cyc %0d, want no event",
                 year, month, day, month_carry, year_carry, wrap, set_err, cyc);
      end else begin
        e = q.pop_front();
        if (int'(year) != e.y || int'(month) != e.m || int'(day) != e.d || int'(max_day) != e.md ||
            month_carry != e.mc || year_carry != e.yc || wrap != e.wr || set_err != e.er ||
            int'(cyc) != e.due) begin
          n_fail++;
          $display("FAIL %s: got %0d-%0d-%0d md=%0d c=%b%b%b e=%b cyc=%0d, want %0d-%0d-%0d md=%0d c=%b%b%b e=%b cyc=%0d",
                   e.nm, year, month, day, max_day, month_carry, year_carry, wrap, set_err, cyc,
                   e.y, e.m, e.d, e.md, e.mc, e.yc, e.wr, e.er, e.due);
        end
      end
    end
  end

  task automatic tick1(string nm, int ey, int em, int ed, bit mc, bit yc, bit wr);
    push(nm, ey, em, ed, mc, yc, wr, 1'b0, int'(cyc) + 2);
    day_tick = 1'b1;
    @(negedge clk) day_tick = 1'b0;
    @(negedge clk);
    cy = ey; cm = em; cd = ed;
  endtask

  task automatic set1(string nm, int y, int m, int d, bit ok);
    if (ok) push(nm, y, m, d, 1'b0, 1'b0, 1'b0, 1'b0, int'(cyc) + 2);
    else    push(nm, cy, cm, cd, 1'b0, 1'b0, 1'b0, 1'b1, int'(cyc) + 2);
    set_year = 10'(y); set_month = 4'(m); set_day = 5'(d);
    set_en = 1'b1;
    @(negedge clk) set_en = 1'b0;
    @(negedge clk);
    if (ok) begin cy = y; cm = m; cd = d; end
  endtask

  task automatic sweep(int n);
    int ny, nm, nd;
    bit mc, yc, wr;
    for (int i = 0; i < n; i++) begin
      ny = cy; nm = cm; nd = cd; mc = 0; yc = 0; wr = 0;
      if (cd < mdays(cy, cm)) nd = cd + 1;
      else begin
        nd = 1; mc = 1;
        if (cm < 12) nm = cm + 1;
        else begin
          nm = 1; yc = 1;
          if (cy < 974) ny = cy + 1;
          else begin ny = 0; wr = 1; end
        end
      end
      tick1("sweep", ny, nm, nd, mc, yc, wr);
    end
  endtask

  initial begin
    int c;
    repeat (2) @(negedge clk);
    chk("rst_year", int'(year), 0);
    chk("rst_month", int'(month), 1);
    chk("rst_day", int'(day), 1);
    chk("rst_pulses", int'({month_carry, year_carry, wrap, set_err}), 0);
    chk("rst_max_day", int'(max_day), 31);
    #1 rst = 1'b0;
    @(negedge clk);

    // Leap February 2028, century years 2100 / 2400, millennium wrap
    set1("set_3_02_28", 3, 2, 28, 1);
    tick1("leap_feb29", 3, 2, 29, 0, 0, 0);
    tick1("leap_mar01", 3, 3, 1, 1, 0, 0);
    set1("set_75_02_28", 75, 2, 28, 1);
    tick1("y2100_mar01", 75, 3, 1, 1, 0, 0);
    set1("set_375_02_28", 375, 2, 28, 1);
    tick1("y2400_feb29", 375, 2, 29, 0, 0, 0);
    set1("set_974_12_31", 974, 12, 31, 1);
    tick1("wrap", 0, 1, 1, 1, 1, 1);

    // Rejected loads leave the date alone
    set1("bad_0_02_29", 0, 2, 29, 0);
    set1("bad_1_04_31", 1, 4, 31, 0);
    set1("bad_975_01_01", 975, 1, 1, 0);
    set1("bad_month13", 0, 13, 1, 0);
    set1("bad_month0", 0, 0, 1, 0);
    set1("bad_day0", 5, 1, 0, 0);
    set1("ok_3_02_29", 3, 2, 29, 1);

    // set_en wins over a simultaneous day_tick
    push("simul_set", 10, 6, 15, 0, 0, 0, 0, int'(cyc) + 2);
    set_year = 10'd10; set_month = 4'd6; set_day = 5'd15;
    set_en = 1'b1; day_tick = 1'b1;
    @(negedge clk) begin set_en = 1'b0; day_tick = 1'b0; end
    repeat (4) @(negedge clk);
    cy = 10; cm = 6; cd = 15;

    // Two back-to-back ticks: second is pended and serviced
    c = int'(cyc);
    push("b2b_16", 10, 6, 16, 0, 0, 0, 0, c + 2);
    push("b2b_17", 10, 6, 17, 0, 0, 0, 0, c + 4);
    day_tick = 1'b1;
    repeat (2) @(negedge clk);
    day_tick = 1'b0;
    repeat (4) @(negedge clk);

    // Three back-to-back ticks: third dropped
    set1("set_10_06_15", 10, 6, 15, 1);
    c = int'(cyc);
    push("tri_16", 10, 6, 16, 0, 0, 0, 0, c + 2);
    push("tri_17", 10, 6, 17, 0, 0, 0, 0, c + 4);
    day_tick = 1'b1;
    repeat (3) @(negedge clk);
    day_tick = 1'b0;
    repeat (5) @(negedge clk);

    // set_en during ADVANCE is pended
    c = int'(cyc);
    push("pend_tick", 10, 6, 18, 0, 0, 0, 0, c + 2);
    push("pend_set", 11, 7, 4, 0, 0, 0, 0, c + 4);
    day_tick = 1'b1;
    @(negedge clk) begin
      day_tick = 1'b0; set_en = 1'b1;
      set_year = 10'd11; set_month = 4'd7; set_day = 5'd4;
    end
    @(negedge clk) set_en = 1'b0;
    repeat (4) @(negedge clk);

    // Asynchronous reset takes effect before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("async_rst_year", int'(year), 0);
    chk("async_rst_month", int'(month), 1);
    chk("async_rst_day", int'(day), 1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cy = 0; cm = 1; cd = 1;

    // Reset during ADVANCE aborts the update
    set1("set_20_05_10", 20, 5, 10, 1);
    day_tick = 1'b1;
    @(negedge clk) day_tick = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("abort_date", int'({year, month, day}), int'({10'd0, 4'd1, 5'd1}));
    chk("abort_pulses", int'({month_carry, year_carry, wrap, set_err}), 0);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    cy = 0; cm = 1; cd = 1;

    // Reference-model sweeps over interesting windows
    sweep(1500);
    set1("set_74_12_25", 74, 12, 25, 1);
    sweep(80);
    set1("set_374_12_25", 374, 12, 25, 1);
    sweep(80);
    set1("set_974_12_20", 974, 12, 20, 1);
    sweep(20);

    repeat (6) @(negedge clk);
    chk("queue_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
